sap_reg_universal: RTL and testbench

WIDTH-bit universal register for the SAP datapath, generalising the 4-bit bus register. It keeps the active-low parallel load and the tri-state bus output. It adds counting (inc/dec), shifting and rotating with serial inputs, a synchronous clear mode, a registered carry/shift-out flag, and a zero flag. It is intended for the program counter, accumulator shift extensions and the output register, all on the shared W bus.

---
 rtl/sap_reg_universal.sv | 52 +++++
 tb/tb_sap_reg_universal.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sap_reg_universal.sv
// sap_reg_universal: WIDTH-bit universal bus register with load, count, shift, rotate, clear and tri-state output
module sap_reg_universal #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             n_le,
  input  logic [2:0]       mode,
  input  logic             ser_l,
  input  logic             ser_r,
  input  logic [WIDTH-1:0] d,
  input  logic             e_saida,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_int,
  output logic             cout,
  output logic             zero
);
  logic [WIDTH-1:0] q_reg, q_nxt;
  logic             cout_reg, c_nxt;
  // next value and flag for each mode; the extra top bit of inc/dec is the carry/borrow
  always_comb begin
    {c_nxt, q_nxt} = {cout_reg, q_reg};
    case (mode)
      3'b001:  {c_nxt, q_nxt} = {1'b0, q_reg} + 1'b1;
      3'b010:  {c_nxt, q_nxt} = {1'b0, q_reg} - 1'b1;
      3'b011:  {c_nxt, q_nxt} = {q_reg, ser_l};
      3'b100:  {q_nxt, c_nxt} = {ser_r, q_reg};
      3'b101:  {c_nxt, q_nxt} = {q_reg, q_reg[WIDTH-1]};
      3'b110:  {q_nxt, c_nxt} = {q_reg[0], q_reg};
      3'b111:  {c_nxt, q_nxt} = '0;
      default: {c_nxt, q_nxt} = {cout_reg, q_reg};
    endcase
  end
  // reset beats load, load beats the selected mode
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg    <= RESET_VAL;
      cout_reg <= 1'b0;
    end else if (!n_le) begin
      q_reg    <= d;
      cout_reg <= 1'b0;
    end else begin
      q_reg    <= q_nxt;
      cout_reg <= c_nxt;
    end
  end
  assign q     = e_saida ? q_reg : {WIDTH{1'bz}};
  assign q_int = q_reg;
  assign cout  = cout_reg;
  assign zero  = (q_reg == '0);
endmodule

// File: tb/tb_sap_reg_universal.sv
// tb_sap_reg_universal: directed and random checks of sap_reg_universal at widths 8, 4 and 16 against a reference model
module tb_sap_reg_universal;
  logic        clk = 0, rst = 0, n_le = 1, ser_l = 0, ser_r = 0, e_a = 1, e_b = 0;
  logic [2:0]  mode = 0;
  logic [15:0] d_in = 0;
  tri   [7:0]  bus;
  logic [7:0]  qi_a, qi_b;
  logic [3:0]  q4, qi_4;
  logic [15:0] q16, qi_16;
  logic [3:0]  co, ze;
  logic [15:0] qv [4];
  logic [15:0] mq [4];
  logic        mc [4];
  int          wd [4] = '{8, 8, 4, 16};
  logic [15:0] rv [4] = '{16'h005A, 16'h0000, 16'h0000, 16'h0000};
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  sap_reg_universal #(.WIDTH(8), .RESET_VAL(8'h5A)) u_a (
    .clk(clk), .rst(rst), .n_le(n_le), .mode(mode), .ser_l(ser_l), .ser_r(ser_r),
    .d(d_in[7:0]), .e_saida(e_a), .q(bus), .q_int(qi_a), .cout(co[0]), .zero(ze[0]));
  sap_reg_universal #(.WIDTH(8)) u_b (
    .clk(clk), .rst(rst), .n_le(n_le), .mode(mode), .ser_l(ser_l), .ser_r(ser_r),
    .d(d_in[7:0]), .e_saida(e_b), .q(bus), .q_int(qi_b), .cout(co[1]), .zero(ze[1]));
  sap_reg_universal #(.WIDTH(4)) u_4 (
    .clk(clk), .rst(rst), .n_le(n_le), .mode(mode), .ser_l(ser_l), .ser_r(ser_r),
    .d(d_in[3:0]), .e_saida(1'b1), .q(q4), .q_int(qi_4), .cout(co[2]), .zero(ze[2]));
  sap_reg_universal #(.WIDTH(16)) u_16 (
    .clk(clk), .rst(rst), .n_le(n_le), .mode(mode), .ser_l(ser_l), .ser_r(ser_r),
    .d(d_in), .e_saida(1'b1), .q(q16), .q_int(qi_16), .cout(co[3]), .zero(ze[3]));

  assign qv[0] = {8'h00, qi_a};
  assign qv[1] = {8'h00, qi_b};
  assign qv[2] = {12'h000, qi_4};
  assign qv[3] = qi_16;

  function automatic logic [16:0] model(int w, logic [15:0] r, logic [15:0] q, logic c,
                                        logic rr, logic nl, logic [2:0] m, logic sl, logic sr, logic [15:0] dd);
    int mask, qi, msb, lsb;
    mask = (1 << w) - 1;
    qi   = int'(q);
    msb  = (qi >> (w - 1)) & 1;
    lsb  = qi & 1;
    if (rr) return {1'b0, r};
    if (!nl) return {1'b0, 16'(int'(dd) & mask)};
    case (m)
      3'd0:    return {c, q};
      3'd1:    return {qi == mask, 16'((qi + 1) & mask)};
      3'd2:    return {qi == 0, 16'((qi - 1) & mask)};
      3'd3:    return {msb[0], 16'(((qi << 1) | int'(sl)) & mask)};
      3'd4:    return {lsb[0], 16'((qi >> 1) | (int'(sr) << (w - 1)))};
      3'd5:    return {msb[0], 16'(((qi << 1) | msb) & mask)};
      3'd6:    return {lsb[0], 16'((qi >> 1) | (lsb << (w - 1)))};
      default: return 17'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s q_int[%0d]", tag, i), 32'(qv[i]), 32'(mq[i]));
      chk($sformatf("%s cout[%0d]", tag, i), 32'(co[i]), 32'(mc[i]));
      chk($sformatf("%s zero[%0d]", tag, i), 32'(ze[i]), 32'(mq[i] == 0));
    end
    chk($sformatf("%s q4", tag), 32'(q4), 32'(mq[2]));
    chk($sformatf("%s q16", tag), 32'(q16), 32'(mq[3]));
    if (e_a) chk($sformatf("%s bus_a", tag), 32'(bus), 32'(mq[0]));
    else if (e_b) chk($sformatf("%s bus_b", tag), 32'(bus), 32'(mq[1]));
  endtask

  task automatic step(input string tag, input logic rr, input logic nl, input logic [2:0] m,
                      input logic sl, input logic sr, input logic [15:0] dd);
    logic [16:0] n;
    rst = rr; n_le = nl; mode = m; ser_l = sl; ser_r = sr; d_in = dd;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      n = model(wd[i], rv[i], mq[i], mc[i], rr, nl, m, sl, sr, dd);
      mq[i] = n[15:0];
      mc[i] = n[16];
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin mq[i] = 0; mc[i] = 0; end
    #2;
    step("reset", 1, 1, 3'd0, 0, 0, 16'h0000);
    chk("reset_val", 32'(qi_a), 32'h5A);
    chk("reset_zero", 32'(ze[0]), 32'd0);
    step("load0", 0, 0, 3'd0, 0, 0, 16'h0000);
    chk("load0_zero", 32'(ze[0]), 32'd1);
    rst = 1; #2; rst = 0;
    step("mid_rst", 0, 1, 3'd0, 0, 0, 16'h0000);
    chk("mid_rst_hold", 32'(qi_a), 32'h00);
    step("load_fe", 0, 0, 3'd0, 0, 0, 16'hFFFE);
    step("inc1", 0, 1, 3'd1, 0, 0, 16'h0000);
    chk("inc_ff", 32'(qi_a), 32'hFF);
    step("inc2", 0, 1, 3'd1, 0, 0, 16'h0000);
    chk("inc_wrap", 32'({co[0], qi_a}), 32'h100);
    chk("inc_wrap4", 32'({co[2], qi_4}), 32'h10);
    chk("inc_wrap16", 32'({co[3], qi_16}), 32'h10000);
    step("inc3", 0, 1, 3'd1, 0, 0, 16'h0000);
    step("load_00", 0, 0, 3'd0, 0, 0, 16'h0000);
    step("dec", 0, 1, 3'd2, 0, 0, 16'h0000);
    chk("dec_wrap", 32'({co[0], qi_a}), 32'h1FF);
    step("load_81", 0, 0, 3'd0, 0, 0, 16'h8181);
    step("shl", 0, 1, 3'd3, 0, 0, 16'h0000);
    chk("shl", 32'({co[0], qi_a}), 32'h102);
    step("shr", 0, 1, 3'd4, 0, 1, 16'h0000);
    chk("shr", 32'({co[0], qi_a}), 32'h081);
    step("rotr", 0, 1, 3'd6, 0, 0, 16'h0000);
    chk("rotr", 32'({co[0], qi_a}), 32'h1C0);
    step("rotl", 0, 1, 3'd5, 0, 0, 16'h0000);
    chk("rotl", 32'({co[0], qi_a}), 32'h181);
    step("load_pri", 0, 0, 3'd1, 1, 1, 16'h0010);
    chk("load_beats_inc", 32'(qi_a), 32'h10);
    step("rst_pri", 1, 0, 3'd0, 0, 0, 16'h0033);
    chk("rst_beats_load", 32'(qi_a), 32'h5A);
    step("load_a5", 0, 0, 3'd0, 0, 0, 16'hA5A5);
    step("clear", 0, 1, 3'd7, 0, 0, 16'h0000);
    chk("clear", 32'({co[0], qi_a}), 32'h000);
    e_a = 0; e_b = 1;
    step("load_20", 0, 0, 3'd0, 0, 0, 16'h0020);
    for (int i = 0; i < 4; i++) step("cnt_hidden", 0, 1, 3'd1, 0, 0, 16'h0000);
    chk("cnt_hidden_a", 32'(qi_a), 32'h24);
    e_a = 1; e_b = 0; #1;
    chk("bus_enable_now", 32'(bus), 32'h24);
    for (int k = 0; k < 300; k++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      e_a = (sel == 0); e_b = (sel == 1);
      step("rand", $urandom_range(0, 19) == 0, $urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), 16'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
